lsu_mem_stage: RTL and testbench

- Memory-access stage of the RV32I core. Sits directly downstream of the execute stage (ALU result = effective address, rs2 = store data) and upstream of writeback.
- Takes one load/store request at a time, encoded with the core's mem_read_t / mem_write_t codes.
- Drives a simple req/gnt/rvalid data-memory bus with byte enables and lane-shifted write data.
- Returns a sign- or zero-extended load result, or an error flag, to writeback.

---
 rtl/lsu_mem_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Memory-access stage of the RV32I core.
// Accepts one load/store from execute, runs it on the req/gnt/rvalid data
// bus and returns an extended load result (or an error) to writeback.
//
// Handshakes:
//   upstream   - a request transfers on a cycle where req_valid && req_ready;
//                req_ready is high only in IDLE.
//   downstream - resp_valid is a single-cycle pulse with no backpressure.
//   bus        - dmem_req is held with stable addr/we/wdata/be until dmem_gnt;
//                read data is taken on dmem_rvalid, in the gnt cycle or later.
module lsu_mem_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_mem_read,
    input  logic [1:0]        req_mem_write,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [2:0] RD_NONE   = 3'b000;
    localparam logic [2:0] RD_BYTE   = 3'b001;
    localparam logic [2:0] RD_HALF   = 3'b010;
    localparam logic [2:0] RD_WORD   = 3'b011;
    localparam logic [2:0] RD_BYTE_U = 3'b100;
    localparam logic [2:0] RD_HALF_U = 3'b101;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_BYTE = 2'b01;
    localparam logic [1:0] WR_HALF = 2'b10;
    localparam logic [1:0] WR_WORD = 2'b11;

    localparam logic [31:0] ERR_DATA = 32'hdead_beef;
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
    // Last counter value before the abort fires; unused when the timeout is off.
    localparam logic [31:0] TO_LAST  = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    logic [1:0]        state;
    logic [31:0]       cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [2:0]        rd_q;
    logic [1:0]        off_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              illegal;
    logic              misaligned;
    logic              noop;
    logic [3:0]        be_n;
    logic [31:0]       wdata_n;
    logic              timeout_hit;

    // Select the addressed byte/half of a bus word and extend it per load type.
    function automatic logic [31:0] extend_load(input logic [2:0]  rd,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        r = word;
        case (rd)
            RD_BYTE:   r = {{24{b[7]}}, b};
            RD_BYTE_U: r = {24'd0, b};
            RD_HALF:   r = {{16{h[15]}}, h};
            RD_HALF_U: r = {16'd0, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    // Classify the incoming request and build its byte enables and lane data.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        noop       = 1'b0;
        be_n       = 4'b0000;
        wdata_n    = 32'd0;

        if ((req_mem_read != RD_NONE && req_mem_write != WR_NONE) ||
            req_mem_read == 3'b110 || req_mem_read == 3'b111) begin
            illegal = 1'b1;
        end

        if (req_mem_read == RD_NONE && req_mem_write == WR_NONE) begin
            noop = 1'b1;
        end

        case (req_mem_read)
            RD_BYTE, RD_BYTE_U: be_n = 4'b0001 << req_addr[1:0];
            RD_HALF, RD_HALF_U: begin
                be_n       = req_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = req_addr[0];
            end
            RD_WORD: begin
                be_n       = 4'b1111;
                misaligned = (req_addr[1:0] != 2'b00);
            end
            default: ;
        endcase

        case (req_mem_write)
            WR_BYTE: begin
                be_n    = 4'b0001 << req_addr[1:0];
                wdata_n = {4{req_wdata[7:0]}};
            end
            WR_HALF: begin
                be_n       = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n    = {2{req_wdata[15:0]}};
                misaligned = req_addr[0];
            end
            WR_WORD: begin
                be_n       = 4'b1111;
                wdata_n    = req_wdata;
                misaligned = (req_addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    assign timeout_hit = TO_EN && (cnt == TO_LAST);

    // Transaction FSM with bus-side registers, timeout counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 32'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            be_q    <= 4'b0000;
            rd_q    <= RD_NONE;
            off_q   <= 2'b00;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Stale gnt/rvalid arriving here are deliberately ignored.
                    if (req_valid) begin
                        if (illegal || misaligned) begin
                            err_q   <= 1'b1;
                            rdata_q <= ERR_DATA;
                            state   <= S_RESP;
                        end else if (noop) begin
                            err_q   <= 1'b0;
                            rdata_q <= 32'd0;
                            state   <= S_RESP;
                        end else begin
                            addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            we_q    <= (req_mem_write != WR_NONE);
                            wdata_q <= wdata_n;
                            be_q    <= be_n;
                            rd_q    <= req_mem_read;
                            off_q   <= req_addr[1:0];
                            err_q   <= 1'b0;
                            rdata_q <= 32'd0;
                            cnt     <= 32'd0;
                            state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A grant in the final timeout cycle still wins over the abort.
                    if (dmem_gnt) begin
                        if (we_q) begin
                            state <= S_RESP;
                        end else if (dmem_rvalid) begin
                            rdata_q <= extend_load(rd_q, off_q, dmem_rdata);
                            state   <= S_RESP;
                        end else begin
                            cnt   <= cnt + 32'd1;
                            state <= S_WAIT;
                        end
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= ERR_DATA;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        rdata_q <= extend_load(rd_q, off_q, dmem_rdata);
                        state   <= S_RESP;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= ERR_DATA;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
    assign resp_err   = resp_valid & err_q;
    assign dmem_req   = (state == S_REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage; cycle 0 is the request-accept cycle.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_mem_read;
    logic [1:0]  req_mem_write;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int total;
    int bad;

    lsu_mem_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_mem_read (req_mem_read),
        .req_mem_write(req_mem_write),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present a request for cycle 0, then move to cycle 1 with it withdrawn
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] rd, input logic [1:0] wr);
        check("req_ready_c0", {31'd0, req_ready}, 32'd1);
        req_valid     = 1'b1;
        req_addr      = addr;
        req_wdata     = wdata;
        req_mem_read  = rd;
        req_mem_write = wr;
        tick();
        req_valid     = 1'b0;
    endtask

    // single-cycle response at the current cycle, idle on the next
    task automatic expect_resp(input string tag, input logic [31:0] rdata, input logic err);
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_rdata"}, resp_rdata, rdata);
        check({tag, "_err"}, {31'd0, resp_err}, {31'd0, err});
        tick();
        check({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    // load with gnt at cycle 1 and rvalid at cycle 2
    task automatic load_1_2(input string tag, input logic [31:0] addr, input logic [2:0] rd,
                            input logic [31:0] word, input logic [3:0] be,
                            input logic [31:0] exp);
        issue(addr, 32'd0, rd, 2'b00);
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({tag, "_be"}, {28'd0, dmem_be}, {28'd0, be});
        check({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt    = 1'b0;
        check({tag, "_c2_req"}, {31'd0, dmem_req}, 32'd0);
        check({tag, "_c2_valid"}, {31'd0, resp_valid}, 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = word;
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        expect_resp(tag, exp, 1'b0);
    endtask

    // store granted at cycle 1
    task automatic store_1(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] wr, input logic [3:0] be, input logic [31:0] lane);
        issue(addr, wdata, 3'b000, wr);
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        check({tag, "_we"}, {31'd0, dmem_we}, 32'd1);
        check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({tag, "_be"}, {28'd0, dmem_be}, {28'd0, be});
        check({tag, "_wdata"}, dmem_wdata, lane);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        expect_resp(tag, 32'd0, 1'b0);
    endtask

    // request answered at cycle 1 without touching the bus
    task automatic local_resp(input string tag, input logic [31:0] addr, input logic [2:0] rd,
                              input logic [1:0] wr, input logic [31:0] rdata, input logic err);
        issue(addr, 32'h1234_5678, rd, wr);
        check({tag, "_noreq"}, {31'd0, dmem_req}, 32'd0);
        expect_resp(tag, rdata, err);
        check({tag, "_noreq2"}, {31'd0, dmem_req}, 32'd0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_addr      = 32'd0;
        req_wdata     = 32'd0;
        req_mem_read  = 3'b000;
        req_mem_write = 2'b00;
        dmem_gnt      = 1'b0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = 32'd0;
        #12;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
        rst_n = 1'b1;
        tick();

        // LB / LBU at 0x1003: top byte 0x80
        load_1_2("lb", 32'h0000_1003, 3'b001, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
        load_1_2("lbu", 32'h0000_1003, 3'b100, 32'h80FF_1234, 4'b1000, 32'h0000_0080);
        // LH lower half, negative; LHU upper half; LW pass-through
        load_1_2("lh_lo", 32'h0000_0100, 3'b010, 32'h1234_8001, 4'b0011, 32'hFFFF_8001);
        load_1_2("lhu_hi", 32'h0000_0102, 3'b101, 32'h9ABC_0000, 4'b1100, 32'h0000_9ABC);
        load_1_2("lw", 32'h0000_0104, 3'b011, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        load_1_2("lb1", 32'h0000_0101, 3'b001, 32'h0000_7F00, 4'b0010, 32'h0000_007F);

        // stores
        store_1("sh", 32'h0000_2002, 32'hAAAA_BEEF, 2'b10, 4'b1100, 32'hBEEF_BEEF);
        store_1("sb", 32'h0000_2001, 32'h1122_33A5, 2'b01, 4'b0010, 32'hA5A5_A5A5);
        store_1("sw", 32'h0000_2004, 32'h0BAD_CAFE, 2'b11, 4'b1111, 32'h0BAD_CAFE);

        // errors and no-op resolved at cycle 1
        local_resp("lw_mis", 32'h0000_0006, 3'b011, 2'b00, 32'hDEAD_BEEF, 1'b1);
        local_resp("sh_mis", 32'h0000_0001, 3'b000, 2'b10, 32'hDEAD_BEEF, 1'b1);
        local_resp("lh_mis", 32'h0000_0003, 3'b010, 2'b00, 32'hDEAD_BEEF, 1'b1);
        local_resp("ill_rw", 32'h0000_0000, 3'b011, 2'b11, 32'hDEAD_BEEF, 1'b1);
        local_resp("ill_rd", 32'h0000_0000, 3'b110, 2'b00, 32'hDEAD_BEEF, 1'b1);
        local_resp("noop", 32'h0000_0040, 3'b000, 2'b00, 32'h0000_0000, 1'b0);

        // LH at 0x0002 with gnt delayed 3 cycles, rvalid in the gnt cycle
        issue(32'h0000_0002, 32'd0, 3'b010, 2'b00);
        for (int i = 1; i <= 3; i++) begin
            check("lhd_req", {31'd0, dmem_req}, 32'd1);
            check("lhd_addr", dmem_addr, 32'h0000_0000);
            check("lhd_be", {28'd0, dmem_be}, 32'h0000_000C);
            tick();
        end
        check("lhd_req4", {31'd0, dmem_req}, 32'd1);
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h7FFE_0000;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        expect_resp("lhd", 32'h0000_7FFE, 1'b0);

        // timeout: LW never granted, req held for 4 cycles then aborted
        issue(32'h0000_0010, 32'd0, 3'b011, 2'b00);
        for (int i = 1; i <= 4; i++) begin
            check("to_req", {31'd0, dmem_req}, 32'd1);
            tick();
        end
        check("to_drop", {31'd0, dmem_req}, 32'd0);
        expect_resp("to", 32'hDEAD_BEEF, 1'b1);

        // reset while in WAIT, then a stale rvalid
        issue(32'h0000_0020, 32'd0, 3'b011, 2'b00);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("wr_in_wait", {31'd0, dmem_req}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("wr_ready", {31'd0, req_ready}, 32'd1);
        check("wr_valid", {31'd0, resp_valid}, 32'd0);
        check("wr_dmem_addr", dmem_addr, 32'd0);
        check("wr_dmem_be", {28'd0, dmem_be}, 32'd0);
        tick();
        rst_n       = 1'b1;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_AAAA;
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        for (int i = 0; i < 2; i++) begin
            check("stale_valid", {31'd0, resp_valid}, 32'd0);
            check("stale_req", {31'd0, dmem_req}, 32'd0);
            tick();
        end
        store_1("sw_after", 32'h0000_0030, 32'h1234_5678, 2'b11, 4'b1111, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop in case the run wedges
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
